timer_bamse: RTL and testbench

- Memory-mapped 16-bit up-counting timer with a 3-bit power-of-two prescaler.
- Sits on the processor's 8-bit port bus; one 8-bit config/status register at address ADDR.
- Raises a sticky interrupt flag on counter overflow.
- Supports one-shot and auto-reload modes; reload value comes from the external timer_conf input.

---
 rtl/timer_bamse_pkg.sv | 18 +
 rtl/timer_bamse_prescaler.sv | 44 ++++
 rtl/timer_bamse.sv | 127 ++++++++++++
 tb/tb_timer_bamse.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/timer_bamse_pkg.sv
// timer_bamse_pkg
// Shared definitions for the timer_bamse port-mapped timer: bit positions
// inside the 8-bit config/status register and the counter widths.
// Ports: none (package).
package timer_bamse_pkg;

  // Register bit positions: {0, presc[2:0], auto_load, en, go, int}
  localparam int INT_BIT   = 0;
  localparam int GO_BIT    = 1;
  localparam int EN_BIT    = 2;
  localparam int AUTO_BIT  = 3;
  localparam int PRESC_LSB = 4;
  localparam int PRESC_MSB = 6;

  localparam int CNT_W = 16;
  localparam int PSC_W = 7;

endpackage

// File: rtl/timer_bamse_prescaler.sv
// timer_bamse_prescaler
// Free-running 7-bit prescaler counter with power-of-two tick select.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   clear - restart the prescaler from zero (timer start)
//   run   - advance the prescaler this cycle (en && go)
//   presc - divide ratio exponent, tick once every 2^presc clocks
//   tick  - one-cycle enable for the main counter
module timer_bamse_prescaler
  import timer_bamse_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       run,
  input  logic [2:0] presc,
  output logic       tick
);

  logic [PSC_W-1:0] psc_cnt_r;
  logic [PSC_W-1:0] mask_s;

  // Low presc bits set in the mask; presc = 0 gives an empty mask so every
  // running cycle ticks.
  always_comb begin
    mask_s = ~(7'h7F << presc);
    tick   = run && ((psc_cnt_r & mask_s) == mask_s);
  end

  // Prescaler counter: cleared on start, frozen whenever the timer is not running.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_cnt_r <= 7'd0;
    end else if (clear) begin
      psc_cnt_r <= 7'd0;
    end else if (run) begin
      psc_cnt_r <= psc_cnt_r + 7'd1;
    end else begin
      psc_cnt_r <= psc_cnt_r;
    end
  end

endmodule

// File: rtl/timer_bamse.sv
// timer_bamse
// Port-mapped 16-bit up-counting timer with power-of-two prescaler, one-shot
// and auto-reload modes and a sticky overflow interrupt flag.
// Ports:
//   clk        - system clock, all state changes on rising edge
//   rst        - synchronous active-high reset
//   timer_conf - reload/start value, sampled at start and at auto-reload
//   address    - port address; register selected when equal to ADDR
//   config_in  - write data {0, presc[2:0], auto_load, en, go, int}
//   config_out - status readback, same layout; go shows the live run state
//   ren        - read strobe (no side effects)
//   wen        - write strobe
module timer_bamse
  import timer_bamse_pkg::*;
#(
  parameter logic [7:0] ADDR = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] timer_conf,
  input  logic [7:0]       address,
  input  logic [7:0]       config_in,
  output logic [7:0]       config_out,
  input  logic             ren,
  input  logic             wen
);

  logic [2:0]       presc_r, presc_n;
  logic             auto_r, auto_n;
  logic             en_r, en_n;
  logic             go_r, go_n;
  logic             int_r, int_n;
  logic [CNT_W-1:0] count_r, count_n;

  logic sel_s;
  logic start_s;
  logic run_s;
  logic tick_s;
  logic ovf_s;

  // Readback is always driven; bit 7 and the read strobe carry no state.
  wire unused_s = &{1'b0, ren, config_in[7]};

  assign sel_s   = wen && (address == ADDR);
  // A start only happens from the stopped state; go=1 while running is a no-op.
  assign start_s = sel_s && config_in[GO_BIT] && !go_r;
  assign run_s   = en_r && go_r;
  assign ovf_s   = tick_s && (count_r == 16'hFFFF);

  assign config_out = {1'b0, presc_r, auto_r, en_r, go_r, int_r};

  timer_bamse_prescaler u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (start_s),
    .run   (run_s),
    .presc (presc_r),
    .tick  (tick_s)
  );

  // Next-state: software write first, hardware overflow afterwards so that the
  // overflow set of int (and one-shot clear of go) wins over the write.
  always_comb begin
    presc_n = presc_r;
    auto_n  = auto_r;
    en_n    = en_r;
    go_n    = go_r;
    int_n   = int_r;
    count_n = count_r;

    if (sel_s) begin
      presc_n = config_in[PRESC_MSB:PRESC_LSB];
      auto_n  = config_in[AUTO_BIT];
      en_n    = config_in[EN_BIT];
      if (!config_in[GO_BIT]) begin
        go_n = 1'b0;
      end else if (!go_r) begin
        go_n = 1'b1;
      end else begin
        go_n = go_r;
      end
      if (!config_in[INT_BIT]) begin
        int_n = 1'b0;
      end else begin
        int_n = int_r;
      end
    end else begin
      presc_n = presc_r;
    end

    if (ovf_s) begin
      int_n = 1'b1;
      if (auto_r) begin
        count_n = timer_conf;
      end else begin
        count_n = 16'h0000;
        go_n    = 1'b0;
      end
    end else if (start_s) begin
      count_n = timer_conf;
    end else if (tick_s) begin
      count_n = count_r + 16'h0001;
    end else begin
      count_n = count_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= 3'd0;
      auto_r  <= 1'b0;
      en_r    <= 1'b0;
      go_r    <= 1'b0;
      int_r   <= 1'b0;
      count_r <= 16'h0000;
    end else begin
      presc_r <= presc_n;
      auto_r  <= auto_n;
      en_r    <= en_n;
      go_r    <= go_n;
      int_r   <= int_n;
      count_r <= count_n;
    end
  end

endmodule

// File: tb/tb_timer_bamse.sv
// tb_timer_bamse
// Directed self-checking bench for timer_bamse. Expected readback values are
// queued when a step is issued and popped when the DUT output is sampled
// (1 time unit after the relevant rising edge).
module tb_timer_bamse;

  localparam logic [7:0] ADDR = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] timer_conf = 16'h0000;
  logic [7:0]  address = 8'h00;
  logic [7:0]  config_in = 8'h00;
  logic [7:0]  config_out;
  logic        ren = 1'b0;
  logic        wen = 1'b0;

  int checks = 0;
  int failures = 0;

  string      tag_q[$];
  logic [7:0] exp_q[$];

  timer_bamse #(.ADDR(ADDR)) dut (
    .clk        (clk),
    .rst        (rst),
    .timer_conf (timer_conf),
    .address    (address),
    .config_in  (config_in),
    .config_out (config_out),
    .ren        (ren),
    .wen        (wen)
  );

  always #5 clk = ~clk;

  // Hold reset over two rising edges; leaves time at edge+1.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One-cycle write; the write takes effect at the rising edge, leaves time at edge+1.
  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    address   = addr;
    config_in = data;
    wen       = 1'b1;
    ren       = 1'b0;
    @(posedge clk);
    #1;
    wen       = 1'b0;
    address   = ADDR;
    config_in = 8'h00;
    ren       = 1'b1;
  endtask

  // Queue an expectation, advance n rising edges, then pop and compare.
  task automatic check_after(input int n, input string tag, input logic [7:0] exp);
    string      t;
    logic [7:0] e;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    assert (config_out === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, config_out, e);
    end
  endtask

  initial begin
    // Reset
    do_reset();
    check_after(0, "reset", 8'h00);

    // One-shot, presc=0, start value FFF0: int visible after the 16th tick edge
    timer_conf = 16'hFFF0;
    do_write(ADDR, 8'h06);
    check_after(15, "oneshot_before_ovf", 8'h06);
    check_after(1,  "oneshot_ovf", 8'h05);
    check_after(20, "oneshot_stays_stopped", 8'h05);

    // Interrupt clear; software cannot set int
    do_write(ADDR, 8'h04);
    check_after(0, "int_clear", 8'h04);
    do_write(ADDR, 8'h05);
    check_after(0, "int_no_sw_set", 8'h04);

    // Prescaler 1: 32 clocks
    do_write(ADDR, 8'h16);
    check_after(31, "presc1_before_ovf", 8'h16);
    check_after(1,  "presc1_ovf", 8'h15);
    do_write(ADDR, 8'h14);
    check_after(0, "presc1_clear", 8'h14);

    // Prescaler 7: 2048 clocks
    do_write(ADDR, 8'h76);
    check_after(2047, "presc7_before_ovf", 8'h76);
    check_after(1,    "presc7_ovf", 8'h75);
    do_write(ADDR, 8'h74);
    check_after(0, "presc7_clear", 8'h74);

    // Auto-reload: overflow every 16 ticks, go stays set
    do_write(ADDR, 8'h0E);
    check_after(15, "auto_before_ovf1", 8'h0E);
    check_after(1,  "auto_ovf1", 8'h0F);
    do_write(ADDR, 8'h0E);
    check_after(0,  "auto_int_cleared", 8'h0E);
    check_after(14, "auto_before_ovf2", 8'h0E);
    check_after(1,  "auto_ovf2", 8'h0F);
    do_write(ADDR, 8'h0C);
    check_after(0,  "auto_stop", 8'h0C);
    check_after(40, "auto_stopped_hold", 8'h0C);

    // Enable gating: 5 ticks, freeze 21 cycles, resume without reload
    do_write(ADDR, 8'h06);
    check_after(4,  "en_running", 8'h06);
    do_write(ADDR, 8'h02);
    check_after(0,  "en_cleared", 8'h02);
    check_after(20, "en_frozen", 8'h02);
    do_write(ADDR, 8'h06);
    check_after(10, "en_resume_before_ovf", 8'h06);
    check_after(1,  "en_resume_ovf", 8'h05);

    // Address decode: write elsewhere is ignored
    do_write(8'h01, 8'h70);
    check_after(0, "addr_mismatch", 8'h05);

    // Overflow coincident with int-clear write: set wins
    do_write(ADDR, 8'h0E);
    check_after(0,  "coinc_start", 8'h0E);
    check_after(15, "coinc_before_ovf", 8'h0E);
    do_write(ADDR, 8'h0E);
    check_after(0,  "coinc_set_wins", 8'h0F);
    // Stop write coincident with the next overflow: stops, int still set
    check_after(15, "coinc2_before_ovf", 8'h0F);
    do_write(ADDR, 8'h0C);
    check_after(0,  "coinc_stop_ovf", 8'h0D);
    check_after(20, "coinc_stop_hold", 8'h0D);

    // Reset mid-count
    do_write(ADDR, 8'h06);
    check_after(5, "midcount_running", 8'h06);
    do_reset();
    check_after(0, "midcount_reset", 8'h00);

    // timer_conf sampled only at start
    timer_conf = 16'hFF00;
    do_write(ADDR, 8'h06);
    timer_conf = 16'hFFFE;
    check_after(255, "conf_sample_before_ovf", 8'h06);
    check_after(1,   "conf_sample_ovf", 8'h05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
